// File: rtl/blink_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | blink_pkg : shared state and error-code encodings for blink_checker  |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package blink_pkg;

  localparam int C_ERR_CODE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_ERROR   = 2'd3
  } state_e;

  typedef enum logic [C_ERR_CODE_W-1:0] {
    ERR_NONE    = 2'd0,
    ERR_PARTIAL = 2'd1,
    ERR_PERIOD  = 2'd2,
    ERR_STALL   = 2'd3
  } err_code_e;

endpackage
`default_nettype wire

// File: rtl/blink_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | blink_checker_if : monitored pattern, clear and status of the checker|
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
interface blink_checker_if #(
  parameter int INPUT_WIDTH = 4,
  parameter int CNT_WIDTH   = 16
);
  import blink_pkg::*;

  logic [INPUT_WIDTH-1:0] in;
  logic                   clear;
  logic                   locked;
  logic [CNT_WIDTH-1:0]   period;
  logic                   err;
  err_code_e              err_code;
  logic [CNT_WIDTH-1:0]   err_count;
  logic [CNT_WIDTH-1:0]   toggle_count;

  modport master (
    output in, clear,
    input  locked, period, err, err_code, err_count, toggle_count
  );

  modport slave (
    input  in, clear,
    output locked, period, err, err_code, err_count, toggle_count
  );

endinterface
`default_nettype wire

// File: rtl/blink_edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | blink_edge_detect : registers the pattern and classifies transitions |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module blink_edge_detect #(
  parameter int INPUT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUT_WIDTH-1:0] in_i,
  output logic                   tr_o,
  output logic                   valid_o,
  output logic                   partial_o
);

  logic [INPUT_WIDTH-1:0] in_q;

  // Reset loads the live input so that releasing rst never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q <= in_i;
    end else begin
      in_q <= in_i;
    end
  end

  assign tr_o      = (in_i != in_q);
  assign valid_o   = (in_i == ~in_q);
  assign partial_o = tr_o & ~valid_o;

endmodule
`default_nettype wire

// File: rtl/blink_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | blink_checker : locks onto a blinker's toggle period and flags faults|
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module blink_checker
  import blink_pkg::*;
#(
  parameter int INPUT_WIDTH = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int LOCK_COUNT  = 4
) (
  input  logic           clk,
  input  logic           rst,
  blink_checker_if.slave bus
);

  localparam int                   C_MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;

  logic w_tr, w_valid, w_partial;
  logic w_cnt_sat;
  logic [CNT_WIDTH:0] w_interval;
  logic w_raise;
  err_code_e w_raise_code;

  state_e                 state_q, state_d;
  err_code_e              err_code_q, err_code_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   ref_q, ref_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d;
  logic [CNT_WIDTH-1:0]   err_count_q, err_count_d;
  logic [CNT_WIDTH-1:0]   toggle_count_q, toggle_count_d;
  logic [C_MATCH_W-1:0]   match_q, match_d;

  blink_edge_detect #(.INPUT_WIDTH(INPUT_WIDTH)) u_edge (
    .clk       (clk),
    .rst       (rst),
    .in_i      (bus.in),
    .tr_o      (w_tr),
    .valid_o   (w_valid),
    .partial_o (w_partial)
  );

  assign w_cnt_sat  = (cnt_q == C_CNT_MAX);
  assign w_interval = {1'b0, cnt_q} + (CNT_WIDTH+1)'(1);

  always_comb begin
    state_d        = state_q;
    err_code_d     = err_code_q;
    ref_d          = ref_q;
    match_d        = match_q;
    period_d       = period_q;
    err_count_d    = err_count_q;
    toggle_count_d = toggle_count_q;
    w_raise        = 1'b0;
    w_raise_code   = ERR_NONE;

    if (w_tr) begin
      cnt_d = '0;
    end else if (w_cnt_sat) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (w_tr) begin
          state_d = ST_ACQUIRE;
          match_d = '0;
        end
      end
      ST_ACQUIRE: begin
        // A saturated count is not a measurable interval, so it restarts matching.
        if (w_partial || (w_valid && w_cnt_sat)) begin
          match_d = '0;
        end else if (w_valid) begin
          if ((match_q != '0) && (w_interval == {1'b0, ref_q})) begin
            match_d = match_q + C_MATCH_W'(1);
          end else begin
            ref_d   = w_interval[CNT_WIDTH-1:0];
            match_d = C_MATCH_W'(1);
          end
          if (match_d == C_MATCH_W'(LOCK_COUNT)) begin
            state_d  = ST_LOCKED;
            period_d = ref_d;
          end
        end
      end
      ST_LOCKED: begin
        if (w_partial) begin
          w_raise      = 1'b1;
          w_raise_code = ERR_PARTIAL;
        end else if (w_valid) begin
          if (w_interval == {1'b0, period_q}) begin
            if (toggle_count_q != C_CNT_MAX) begin
              toggle_count_d = toggle_count_q + CNT_WIDTH'(1);
            end
          end else begin
            w_raise      = 1'b1;
            w_raise_code = ERR_PERIOD;
          end
        end else if (w_interval == {1'b0, period_q}) begin
          w_raise      = 1'b1;
          w_raise_code = ERR_STALL;
        end
      end
      ST_ERROR: begin
        if (bus.clear) begin
          state_d    = ST_IDLE;
          err_code_d = ERR_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_raise) begin
      state_d    = ST_ERROR;
      err_code_d = w_raise_code;
      if (err_count_q != C_CNT_MAX) begin
        err_count_d = err_count_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      err_code_q     <= ERR_NONE;
      cnt_q          <= '0;
      ref_q          <= '0;
      match_q        <= '0;
      period_q       <= '0;
      err_count_q    <= '0;
      toggle_count_q <= '0;
    end else begin
      state_q        <= state_d;
      err_code_q     <= err_code_d;
      cnt_q          <= cnt_d;
      ref_q          <= ref_d;
      match_q        <= match_d;
      period_q       <= period_d;
      err_count_q    <= err_count_d;
      toggle_count_q <= toggle_count_d;
    end
  end

  assign bus.locked       = (state_q == ST_LOCKED);
  assign bus.err          = (state_q == ST_ERROR);
  assign bus.period       = period_q;
  assign bus.err_code     = err_code_q;
  assign bus.err_count    = err_count_q;
  assign bus.toggle_count = toggle_count_q;

endmodule
`default_nettype wire

// File: tb/tb_blink_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_blink_checker : scoreboard bench for blink_checker (CNT_WIDTH=4)  |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_blink_checker;
  import blink_pkg::*;

  localparam int IW = 4;
  localparam int CW = 4;
  localparam int LC = 4;

  typedef struct packed {
    logic          locked;
    logic [CW-1:0] period;
    logic          err;
    logic [1:0]    code;
    logic [CW-1:0] ec;
    logic [CW-1:0] tc;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  obs_t sb[$];
  obs_t got, want;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  blink_checker_if #(.INPUT_WIDTH(IW), .CNT_WIDTH(CW)) bus ();

  blink_checker #(.INPUT_WIDTH(IW), .CNT_WIDTH(CW), .LOCK_COUNT(LC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic obs_t mk(logic l, int p, logic e, int c, int ec, int tc);
    obs_t o;
    o.locked = l;
    o.period = CW'(p);
    o.err    = e;
    o.code   = 2'(c);
    o.ec     = CW'(ec);
    o.tc     = CW'(tc);
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.locked = bus.locked;
    o.period = bus.period;
    o.err    = bus.err;
    o.code   = bus.err_code;
    o.ec     = bus.err_count;
    o.tc     = bus.toggle_count;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.in    = '0;
    bus.clear = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic first_edge();
    bus.in = ~bus.in;
    tick();
  endtask

  // One transition arriving p cycles after the previous one.
  task automatic interval(int p);
    repeat (p - 1) tick();
    bus.in = ~bus.in;
    tick();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.clear = 1'b0;
    bus.in    = 4'b1010;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    tick();
    tick();
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_state: got %p expected %p", got, want); end
    rst = 1'b0;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    tick();
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_release: got %p expected %p", got, want); end
  endtask

  task automatic test_lock_fast();
    do_reset();
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    first_edge();
    repeat (3) interval(1);
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL not_locked_4th: got %p expected %p", got, want); end
    sb.push_back(mk(1, 1, 0, 0, 0, 0));
    interval(1);
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL lock_5th: got %p expected %p", got, want); end
    sb.push_back(mk(1, 1, 0, 0, 0, 10));
    repeat (10) interval(1);
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL toggle_10: got %p expected %p", got, want); end
    sb.push_back(mk(1, 1, 0, 0, 0, 15));
    repeat (10) interval(1);
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL toggle_sat: got %p expected %p", got, want); end
  endtask

  task automatic test_period_err();
    do_reset();
    sb.push_back(mk(1, 3, 0, 0, 0, 0));
    first_edge();
    repeat (4) interval(3);
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL lock_p3: got %p expected %p", got, want); end
    sb.push_back(mk(1, 3, 0, 0, 0, 1));
    interval(3);
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL toggle_p3: got %p expected %p", got, want); end
    sb.push_back(mk(0, 3, 1, 2, 1, 1));
    interval(2);
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL period_err: got %p expected %p", got, want); end
  endtask

  task automatic test_stall_clear();
    do_reset();
    first_edge();
    repeat (4) interval(3);
    bus.clear = 1'b1;
    sb.push_back(mk(1, 3, 0, 0, 0, 0));
    tick();
    bus.clear = 1'b0;
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL clear_in_locked: got %p expected %p", got, want); end
    sb.push_back(mk(1, 3, 0, 0, 0, 0));
    tick();
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL no_stall_early: got %p expected %p", got, want); end
    sb.push_back(mk(0, 3, 1, 3, 1, 0));
    tick();
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL stall: got %p expected %p", got, want); end
    sb.push_back(mk(0, 3, 1, 3, 1, 0));
    bus.in = ~bus.in;
    tick();
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL err_holds: got %p expected %p", got, want); end
    bus.clear = 1'b1;
    sb.push_back(mk(0, 3, 0, 0, 1, 0));
    tick();
    bus.clear = 1'b0;
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL clear_to_idle: got %p expected %p", got, want); end
    sb.push_back(mk(1, 3, 0, 0, 1, 0));
    first_edge();
    repeat (4) interval(3);
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL relock_after_clear: got %p expected %p", got, want); end
  endtask

  task automatic test_partial();
    do_reset();
    first_edge();
    repeat (4) interval(1);
    sb.push_back(mk(0, 1, 1, 1, 1, 0));
    bus.in = bus.in ^ 4'b0011;
    tick();
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL partial_locked: got %p expected %p", got, want); end
    do_reset();
    first_edge();
    repeat (2) interval(1);
    bus.in = bus.in ^ 4'b0011;
    tick();
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    repeat (3) interval(1);
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL acq_partial_restart: got %p expected %p", got, want); end
    sb.push_back(mk(1, 1, 0, 0, 0, 0));
    interval(1);
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL acq_partial_lock: got %p expected %p", got, want); end
  endtask

  task automatic test_acquire_change();
    do_reset();
    first_edge();
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    interval(2); interval(2); interval(3); interval(3); interval(3);
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL acq_not_yet: got %p expected %p", got, want); end
    sb.push_back(mk(1, 3, 0, 0, 0, 0));
    interval(3);
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL acq_lock_p3: got %p expected %p", got, want); end
    rst = 1'b1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    tick();
    rst = 1'b0;
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rst_mid_locked: got %p expected %p", got, want); end
  endtask

  task automatic test_cnt_saturation();
    do_reset();
    first_edge();
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    repeat (4) interval(20);
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL sat_no_lock: got %p expected %p", got, want); end
    sb.push_back(mk(1, 3, 0, 0, 0, 0));
    repeat (4) interval(3);
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL lock_after_sat: got %p expected %p", got, want); end
  endtask

  task automatic test_err_count_sat();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      first_edge();
      repeat (4) interval(1);
      sb.push_back(mk(0, 1, 1, 3, (i + 1 > 15) ? 15 : i + 1, 0));
      tick();
      got = sample(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL err_count_%0d: got %p expected %p", i, got, want); end
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
    end
  endtask

  task automatic test_rst_with_clear();
    do_reset();
    first_edge();
    repeat (4) interval(1);
    tick();
    rst       = 1'b1;
    bus.clear = 1'b1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    tick();
    rst       = 1'b0;
    bus.clear = 1'b0;
    got = sample(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rst_and_clear: got %p expected %p", got, want); end
  endtask

  initial begin
    bus.in    = '0;
    bus.clear = 1'b0;
    test_reset();
    test_lock_fast();
    test_period_err();
    test_stall_clear();
    test_partial();
    test_acquire_change();
    test_cnt_saturation();
    test_err_count_sat();
    test_rst_with_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/blink_checker.md
Name: blink_checker

Overview:
- Receive-side counterpart of the blinker: watches an OUTPUT_WIDTH-wide toggling pattern and measures its toggle interval in clk cycles.
- Locks onto a stable period and checks every later transition against it.
- Flags partial toggles, wrong intervals and stalls. Used in benches and on-board self-test to monitor a blinker output.

Parameters:
INPUT_WIDTH, 4, width of monitored pattern bus
CNT_WIDTH, 16, width of interval counter, period and event counters
LOCK_COUNT, 4, consecutive equal intervals required to lock (>=1)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
in  in  INPUT_WIDTH  monitored pattern, synchronous to clk
clear  in  1  leaves ERROR and returns to IDLE; ignored in other states
locked  out  1  high while in LOCKED
period  out  CNT_WIDTH  locked interval in cycles; 0 until first lock
err  out  1  high while in ERROR
err_code  out  2  0 none, 1 PARTIAL, 2 PERIOD, 3 STALL
err_count  out  CNT_WIDTH  ERROR entries since rst, saturating
toggle_count  out  CNT_WIDTH  valid in-period transitions while LOCKED, saturating

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; locked=0, period=0, err=0, err_code=0, err_count=0, toggle_count=0; cnt=0, match=0; in_q<=in, so no spurious edge.
- Sampling: in_q registers in every cycle. tr = (in != in_q). valid = (in == ~in_q), meaning all bits flipped. partial = tr & ~valid.
- cnt: cleared to 0 on any tr, else increments, saturating at all-ones. Interval I = cnt+1 at a transition, computed CNT_WIDTH+1 wide.
- A blinker toggling every cycle gives I=1.
- All outputs are registered. An event sampled at edge N is visible after edge N.
- IDLE: any tr -> ACQUIRE, match=0. No interval is recorded for this first transition.
- ACQUIRE:
  - valid with match==0: ref=I, match=1.
  - valid with I==ref: match++.
  - valid with I!=ref: ref=I, match=1.
  - partial: match=0.
  - When match would reach LOCK_COUNT: -> LOCKED, period=ref, locked=1. No errors are raised in ACQUIRE.
- LOCKED:
  - valid with I==period: toggle_count++.
  - valid with I!=period (always shorter, since longer is caught by stall): -> ERROR, code PERIOD.
  - partial: -> ERROR, code PARTIAL. PARTIAL takes priority over PERIOD.
  - No tr and cnt+1 == period, meaning the next transition would be late: -> ERROR, code STALL.
- ERROR:
  - Entry: err=1, locked=0, err_count++ (saturating). err_code and period hold; cnt keeps running.
  - clear=1: -> IDLE, err=0, err_code=0. period and counters hold.
  - clear in other states has no effect.
- Simultaneous rst and clear: rst wins.
- Reset mid-operation: full reset as above on the next edge.
- Saturation: cnt stuck at max in ACQUIRE never matches a real interval. Counters never wrap.

Decomposition:
- Package blink_pkg holds:
  - state enum: IDLE, ACQUIRE, LOCKED, ERROR.
  - err_code enum: NONE, PARTIAL, PERIOD, STALL.
  - localparam for err_code width (2).
- One sub-module, blink_edge_detect, parameterised by INPUT_WIDTH.
  - Contents: the in_q register plus the tr, valid and partial decode.
  - Reset: loads in_q from in.
- FSM, counters and compare stay in blink_checker.

Test Plan:
- Blinker with OUTPUT_WIDTH=4, toggling every cycle (0000/1111) from rst release; LOCK_COUNT=4 -> locked=1 after the 5th transition, period=1, err=0; toggle_count=10 after 10 further cycles.
- Pattern toggles every 3 cycles, locked; then one toggle 2 cycles after the previous one -> err=1, err_code=2 (PERIOD), locked=0, err_count=1.
- Locked at period=3; in frozen -> err_code=3 (STALL) registered 3 cycles after the last transition (cnt+1==3 with no tr); then clear=1 for 1 cycle -> err=0, state IDLE, period stays 3.
- Locked at period=1; in changes 0000->0011 -> err_code=1 (PARTIAL). Separately, in ACQUIRE, the same partial change only restarts matching: lock occurs 4 valid intervals later.
- Intervals in ACQUIRE of 2,2,3,3,3,3 -> lock with period=3, no err; then rst asserted mid-LOCKED -> all outputs back to reset values the next cycle.
- Force 2^CNT_WIDTH errors (use CNT_WIDTH=4: 16 errors), each followed by clear -> err_count=15 and stays 15.
